outport_uart_tx: RTL and testbench
==================================

Name: outport_uart_tx

Overview:
- Downstream consumer of the datapath's output port: captures 32-bit words written by the CPU (out-port enable plus bus value) into a small FIFO.
- Serializes each word as four 8N1 UART bytes on a single tx pin, least-significant byte first.
- Exposes full/empty/overflow status so the control unit or software can throttle out-port writes.
- Sits between the datapath's out-port write strobe and the board-level serial pin.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit entries; power of two, minimum 2.
- CLKS_PER_BIT, 16, clock cycles per UART bit; minimum 2.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe, one word per cycle high; driven by the out-port enable.
- wr_data  input  32  word to transmit; sampled when wr_en=1.
- full  output  1  count==FIFO_DEPTH.
- empty  output  1  count==0.
- count  output  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- overflow  output  1  sticky; set when a write is attempted while full.
- busy  output  1  serializer not in IDLE.
- tx  output  1  serial line; idles high.

Behaviour:
- Reset (reset=0, asynchronous): FIFO flushed, read/write pointers=0, count=0, empty=1, full=0, overflow=0, state=IDLE, busy=0, tx=1. This applies mid-frame too: tx returns high immediately and the partial word is discarded.
- Push: on an edge with wr_en=1 and full=0, store wr_data at wr_ptr; wr_ptr wraps modulo FIFO_DEPTH.
- Push while full: on an edge with wr_en=1 and full=1, data is dropped and overflow is set. This holds even if a pop occurs on the same edge. Full is evaluated from registered count.
- Pop: on an edge with state=IDLE and empty=0, the head word loads into the shift register, rd_ptr advances, byte_idx=0, state becomes START.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- count, full and empty are registered and update on the same edge as the push/pop.
- Serializer FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (next byte: START | last byte: IDLE).
  - Each state holds tx for exactly CLKS_PER_BIT cycles, timed by a baud counter reset on every bit boundary.
  - START: tx=0.
  - DATA: 8 bits of the current byte, LSB first; bit_idx counts 0..7.
  - STOP: tx=1.
  - After STOP, if byte_idx<3: byte_idx++ and go to START. Else go to IDLE.
- tx is registered: it changes on the edge that enters a state.
- Latency: a write at edge k into an empty, idle block gives count=1 after k. The pop occurs at edge k+1, where tx falls.
- Word frame length: 4*10*CLKS_PER_BIT cycles, plus 1 IDLE cycle (tx=1) before the next pop.
- busy=1 from the pop edge until the edge returning to IDLE.
- Byte order: byte0=word[7:0], byte3=word[31:24].
- overflow clears only on reset.

Optional Feature:
- Macro: OUTPORT_UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 11 bits per byte, and word frame length becomes 44*CLKS_PER_BIT.
- Undefined: no PARITY state; 8N1, 10 bits per byte.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4 unless noted.
1. Reset: hold reset=0 and toggle wr_en -> tx=1, empty=1, count=0, busy=0, overflow=0. Assert reset low mid-frame -> tx=1 the same cycle, count=0.
2. Single word:
   - Stimulus: write 0x000000A5.
   - Required: tx low for cycles 1-4 after the pop. Data bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop high for 4 cycles. Next three bytes are 0x00.
   - busy is high for 160 cycles, then one idle cycle.
3. Byte order: write 0x12345678 -> decoded bytes in order are 0x78, 0x56, 0x34, 0x12.
4. Full/overflow:
   - Stimulus: 6 back-to-back writes of 1..6 while idle.
   - Required: word 1 pops at once and words 2-5 fill the FIFO (full=1, count=4). Word 6 is dropped and overflow=1.
   - Transmitted sequence is 1,2,3,4,5.
5. Simultaneous push/pop:
   - Stimulus: with count=2, write on the exact edge the serializer pops.
   - Required: count stays 2 and the new word is transmitted last.
6. Parity (OUTPORT_UART_PARITY_EN defined): write 0x00000007 -> byte0 parity bit=1, bytes 1-3 parity bit=0; word frame length 176 cycles.

Source files
------------

// File: rtl/outport_uart_tx.sv
// Out-port word FIFO feeding a UART serializer: four bytes per word, LSB byte first, 8N1.
// Define OUTPORT_UART_PARITY_EN to insert an even-parity bit after the data bits (11-bit byte frame).
module outport_uart_tx #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [31:0]                 wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        busy,
  output logic                        tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef OUTPORT_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   word_q, word_d;
  logic          tx_q, tx_d;

  logic          push, pop, baud_last;
  logic [7:0]    cur_byte;

  // Full is judged on the registered count, so a write while full is dropped even if a pop frees a slot this edge.
  assign push      = wr_en && !full_q;
  assign pop       = (state_q == S_IDLE) && !empty_q;
  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    full_d     = (count_d == COUNT_FULL);
    empty_d    = (count_d == '0);
    overflow_d = overflow_q | (wr_en & full_q);
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d    = S_START;
          word_d     = mem_q[rd_ptr_q];
          byte_idx_d = '0;
          baud_d     = '0;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          baud_d    = '0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef OUTPORT_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef OUTPORT_UART_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // The current byte always sits in word[7:0]; shifting exposes the next one.
          if (byte_idx_q != 2'd3) begin
            state_d    = S_START;
            byte_idx_d = byte_idx_q + 2'd1;
            word_d     = word_q >> 8;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cur_byte = word_d[7:0];
    tx_d     = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte[bit_idx_d];
`ifdef OUTPORT_UART_PARITY_EN
      S_PARITY: tx_d = ^cur_byte;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != S_IDLE);
  assign tx       = tx_q;

endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed bench for outport_uart_tx: table of words with hand-decoded bytes plus FIFO/reset corner sequences.
module tb_outport_uart_tx;

  localparam int C     = 4;
  localparam int DEPTH = 4;
`ifdef OUTPORT_UART_PARITY_EN
  localparam int BPB = 11;
`else
  localparam int BPB = 10;
`endif
  localparam int FRAME = 4 * BPB * C;

  logic        clock;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full, empty, overflow, busy, tx;
  logic [2:0]  count;

  int checks;
  int failures;

  outport_uart_tx #(.FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .overflow(overflow),
    .busy    (busy),
    .tx      (tx)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3;
    logic [3:0]  par;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] d);
    @(negedge clock);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clock);
    wr_en   = 1'b0;
  endtask

  // Captures one whole word frame starting at the first low tx sample, then the trailing idle cycle.
  task automatic rx_word(input string nm, output logic [31:0] w, output logic [3:0] par, output int waited);
    logic s_tx [FRAME];
    logic got, good, v;
    int   busy_cnt, base;
    w = '0; par = '0; waited = 0; got = 1'b0; good = 1'b1; busy_cnt = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clock);
      if (tx === 1'b0) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      chk({nm, "_start_timeout"}, 32'd0, 32'd1);
      return;
    end
    s_tx[0] = tx;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    for (int i = 1; i < FRAME; i++) begin
      @(negedge clock);
      s_tx[i] = tx;
      if (busy === 1'b1) busy_cnt++;
    end
    for (int j = 0; j < 4; j++) begin
      for (int b = 0; b < BPB; b++) begin
        base = (j * BPB + b) * C;
        v = s_tx[base];
        for (int s = 1; s < C; s++) if (s_tx[base + s] !== v) good = 1'b0;
        if (b == 0) begin
          if (v !== 1'b0) good = 1'b0;
        end else if (b <= 8) begin
          w[j*8 + b - 1] = v;
        end else if (b == BPB - 1) begin
          if (v !== 1'b1) good = 1'b0;
        end else begin
          par[j] = v;
        end
      end
    end
    chk({nm, "_frame_shape"}, {31'd0, good}, 32'd1);
    chk({nm, "_busy_cycles"}, busy_cnt, FRAME);
    @(negedge clock);
    chk({nm, "_idle_tx"}, {31'd0, tx}, 32'd1);
    chk({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] rw;
  logic [3:0]  rp;
  int          rwait;

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; wr_en = 1'b0; wr_data = '0;

    vecs[0] = '{32'h0000_00A5, 8'hA5, 8'h00, 8'h00, 8'h00, 4'b0000};
    vecs[1] = '{32'h1234_5678, 8'h78, 8'h56, 8'h34, 8'h12, 4'b0100};
    vecs[2] = '{32'hDEAD_BEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 4'b0101};
    vecs[3] = '{32'h0000_0007, 8'h07, 8'h00, 8'h00, 8'h00, 4'b0001};
    vecs[4] = '{32'hFFFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b0000};

    // Reset held while writes are attempted.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      wr_en   = ~wr_en;
      wr_data = 32'hFFFF_FFFF;
    end
    @(negedge clock);
    chk("rst_tx",       {31'd0, tx},       32'd1);
    chk("rst_empty",    {31'd0, empty},    32'd1);
    chk("rst_full",     {31'd0, full},     32'd0);
    chk("rst_count",    {29'd0, count},    32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    wr_en = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_rst_count", {29'd0, count}, 32'd0);

    // Table: one word at a time into an idle block.
    for (int i = 0; i < 5; i++) begin
      write_word(vecs[i].word);
      chk($sformatf("v%0d_lat_count", i), {29'd0, count}, 32'd1);
      chk($sformatf("v%0d_lat_tx", i),    {31'd0, tx},    32'd1);
      rx_word($sformatf("v%0d", i), rw, rp, rwait);
      chk($sformatf("v%0d_pop_latency", i), rwait, 0);
      chk($sformatf("v%0d_b0", i), {24'd0, rw[7:0]},   {24'd0, vecs[i].b0});
      chk($sformatf("v%0d_b1", i), {24'd0, rw[15:8]},  {24'd0, vecs[i].b1});
      chk($sformatf("v%0d_b2", i), {24'd0, rw[23:16]}, {24'd0, vecs[i].b2});
      chk($sformatf("v%0d_b3", i), {24'd0, rw[31:24]}, {24'd0, vecs[i].b3});
`ifdef OUTPORT_UART_PARITY_EN
      chk($sformatf("v%0d_parity", i), {28'd0, rp}, {28'd0, vecs[i].par});
`endif
    end

    // Six back-to-back writes: 1 pops, 2..5 fill, 6 dropped.
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          @(negedge clock);
          if (i == 6) begin
            chk("ff_full_before6",  {31'd0, full},     32'd1);
            chk("ff_count_before6", {29'd0, count},    32'd4);
            chk("ff_ovf_before6",   {31'd0, overflow}, 32'd0);
          end
          wr_en   = 1'b1;
          wr_data = i;
        end
        @(negedge clock);
        wr_en = 1'b0;
        chk("ff_overflow", {31'd0, overflow}, 32'd1);
        chk("ff_count",    {29'd0, count},    32'd4);
        chk("ff_full",     {31'd0, full},     32'd1);
      end
      begin
        for (int k = 1; k <= 5; k++) begin
          rx_word($sformatf("ff_w%0d", k), rw, rp, rwait);
          chk($sformatf("ff_w%0d_data", k), rw, k);
          if (k > 1) chk($sformatf("ff_w%0d_gap", k), rwait, 0);
        end
      end
    join
    chk("ff_drain_empty",  {31'd0, empty},    32'd1);
    chk("ff_drain_count",  {29'd0, count},    32'd0);
    chk("ff_ovf_sticky",   {31'd0, overflow}, 32'd1);

    // Push on the very edge the serializer pops, with two words queued.
    fork
      begin
        @(negedge clock); wr_en = 1'b1; wr_data = 32'hA1B2_C3D4;
        @(negedge clock); wr_data = 32'h0BAD_F00D;
        @(negedge clock); wr_data = 32'h5555_AAAA;
        @(negedge clock); wr_en = 1'b0;
        chk("pp_count_queued", {29'd0, count}, 32'd2);
        for (int i = 0; i < 400; i++) begin
          @(negedge clock);
          if (busy === 1'b0) break;
        end
        chk("pp_idle_reached", {31'd0, busy}, 32'd0);
        wr_en = 1'b1; wr_data = 32'hC0FF_EE01;
        @(negedge clock);
        wr_en = 1'b0;
        chk("pp_count_same", {29'd0, count}, 32'd2);
        chk("pp_busy",       {31'd0, busy},  32'd1);
      end
      begin
        rx_word("pp_w0", rw, rp, rwait); chk("pp_w0_data", rw, 32'hA1B2_C3D4);
        rx_word("pp_w1", rw, rp, rwait); chk("pp_w1_data", rw, 32'h0BAD_F00D);
        rx_word("pp_w2", rw, rp, rwait); chk("pp_w2_data", rw, 32'h5555_AAAA);
        rx_word("pp_w3", rw, rp, rwait); chk("pp_w3_data", rw, 32'hC0FF_EE01);
      end
    join

    // Asynchronous reset in the middle of a zero-data byte.
    write_word(32'h0);
    write_word(32'h0);
    repeat (10) @(negedge clock);
    chk("mr_pre_tx",    {31'd0, tx},    32'd0);
    chk("mr_pre_count", {29'd0, count}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mr_tx",       {31'd0, tx},       32'd1);
    chk("mr_count",    {29'd0, count},    32'd0);
    chk("mr_busy",     {31'd0, busy},     32'd0);
    chk("mr_empty",    {31'd0, empty},    32'd1);
    chk("mr_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("mr_after_tx",   {31'd0, tx},   32'd1);
    chk("mr_after_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
